// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: control inputs, decode-side handshake and the
// instruction memory port A.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   start_i;
  logic                   halt_i;
  logic                   stall_i;
  logic                   redirect_i;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0]  pc_o;
  logic                   valid_o;
  logic                   busy_o;

  modport master (
    input  start_i, halt_i, stall_i, redirect_i, redirect_pc, imem_data,
    output imem_addr, instr_o, pc_o, valid_o, busy_o
  );

  modport slave (
    output start_i, halt_i, stall_i, redirect_i, redirect_pc, imem_data,
    input  imem_addr, instr_o, pc_o, valid_o, busy_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one word address per cycle to a 1-cycle sync
// memory and presents each returned word with its PC under valid/stall.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   hold;
  logic [INSTR_WIDTH-1:0] instr;

  assign hold = rsp_valid_q & bus.stall_i;

  // While held, re-read the displayed word so imem_data stays stable.
  assign bus.imem_addr = hold ? rsp_pc_q : pc_q;
  assign instr         = bus.imem_data;
  assign bus.instr_o   = instr;
  assign bus.pc_o      = rsp_pc_q;
  assign bus.valid_o   = rsp_valid_q;
  assign bus.busy_o    = (state == RUN);

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    case (state)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        if (bus.halt_i) begin
          state_d     = HALT;
          rsp_valid_d = 1'b0;
          if (bus.redirect_i) pc_d = bus.redirect_pc;
        end else if (bus.redirect_i) begin
          pc_d        = bus.redirect_pc;
          rsp_valid_d = 1'b0;
        end else if (!hold) begin
          rsp_valid_d = 1'b1;
          rsp_pc_d    = pc_q;
          pc_d        = pc_q + ADDR_WIDTH'(1);
        end
      end
      HALT: begin
        if (bus.redirect_i) pc_d = bus.redirect_pc;
        if (bus.start_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (RESET_PC 0 and 0xFFFE)
// share stimulus; a spec-level model is compared every negedge.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [15:0] rpc = '0;
  int          vectors = 0, miscompares = 0;
  logic [15:0] got_acc[$];
  logic [15:0] exp_acc[$];

  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(32)) bus0 ();
  instruction_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(32)) bus1 ();

  instruction_fetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'h0000))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instruction_fetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'hFFFE))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.start_i = start;    assign bus1.start_i = start;
  assign bus0.halt_i = halt;      assign bus1.halt_i = halt;
  assign bus0.stall_i = stall;    assign bus1.stall_i = stall;
  assign bus0.redirect_i = redirect; assign bus1.redirect_i = redirect;
  assign bus0.redirect_pc = rpc;  assign bus1.redirect_pc = rpc;

  // Memory word k holds 0xA000_0000 + k, one-cycle read latency.
  always @(posedge clk) begin
    bus0.imem_data <= 32'hA000_0000 + 32'(bus0.imem_addr);
    bus1.imem_data <= 32'hA000_0000 + 32'(bus1.imem_addr);
  end

  // Model: running flag, next PC to fetch, and the item currently shown.
  int          m_mode[2];   // 0 stopped-before-start, 1 running, 2 halted
  logic [15:0] m_next[2];
  logic [15:0] m_pc[2];
  bit          m_vld[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_mode[i] = 0; m_next[i] = (i == 0) ? 16'h0000 : 16'hFFFE;
        m_pc[i] = '0;  m_vld[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (halt || redirect) begin
          m_vld[i] = 0;
          if (redirect) m_next[i] = rpc;
          if (halt) m_mode[i] = 2;
        end else if (!(m_vld[i] && stall)) begin
          m_vld[i] = 1; m_pc[i] = m_next[i]; m_next[i] = m_next[i] + 16'd1;
        end
      end else begin
        if (m_mode[i] == 2 && redirect) m_next[i] = rpc;
        if (start) m_mode[i] = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic v, input logic b, input logic [15:0] a,
                     input logic [15:0] p, input logic [31:0] ins);
    chk($sformatf("dut%0d.valid_o", i), 32'(v), 32'(m_vld[i]));
    chk($sformatf("dut%0d.busy_o", i), 32'(b), 32'(m_mode[i] == 1));
    chk($sformatf("dut%0d.imem_addr", i), 32'(a), 32'((m_vld[i] && stall) ? m_pc[i] : m_next[i]));
    chk($sformatf("dut%0d.pc_o", i), 32'(p), 32'(m_pc[i]));
    if (m_vld[i]) chk($sformatf("dut%0d.instr_o", i), ins, 32'hA000_0000 + 32'(m_pc[i]));
  endtask

  always @(negedge clk) begin
    cmp(0, bus0.valid_o, bus0.busy_o, bus0.imem_addr, bus0.pc_o, bus0.instr_o);
    cmp(1, bus1.valid_o, bus1.busy_o, bus1.imem_addr, bus1.pc_o, bus1.instr_o);
    if (bus0.valid_o && !stall && !redirect && !halt) got_acc.push_back(bus0.pc_o);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("reset valid", 32'(bus0.valid_o), 0);
    chk("reset busy", 32'(bus0.busy_o), 0);
    chk("reset addr0", 32'(bus0.imem_addr), 32'h0000);
    chk("reset addr1", 32'(bus1.imem_addr), 32'hFFFE);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("first run cycle valid", 32'(bus0.valid_o), 0);
    chk("first run cycle addr", 32'(bus0.imem_addr), 32'h0000);
    step();
    chk("start pc0", 32'(bus0.pc_o), 32'h0000);
    chk("start instr0", bus0.instr_o, 32'hA000_0000);
    chk("wrap pc a", 32'(bus1.pc_o), 32'hFFFE);
    step();
    chk("wrap pc b", 32'(bus1.pc_o), 32'hFFFF);
    step();
    chk("wrap pc c", 32'(bus1.pc_o), 32'h0000);
    chk("wrap instr c", bus1.instr_o, 32'hA000_0000);
    step();
    chk("wrap pc d", 32'(bus1.pc_o), 32'h0001);
    chk("seq pc3", 32'(bus0.pc_o), 32'h0003);
    step(2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall pc", 32'(bus0.pc_o), 32'h0005);
      chk("stall instr", bus0.instr_o, 32'hA000_0005);
      chk("stall addr", 32'(bus0.imem_addr), 32'h0005);
    end
    stall = 1'b0;
    step();
    chk("after stall pc", 32'(bus0.pc_o), 32'h0006);
    step(2);
    chk("pc8", 32'(bus0.pc_o), 32'h0008);
    stall = 1'b1; redirect = 1'b1; rpc = 16'h0100;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("redir bubble valid", 32'(bus0.valid_o), 0);
    chk("redir bubble addr", 32'(bus0.imem_addr), 32'h0100);
    step();
    chk("redir target pc", 32'(bus0.pc_o), 32'h0100);
    chk("redir target instr", bus0.instr_o, 32'hA000_0100);
    step();
    redirect = 1'b1; rpc = 16'h000A;
    step(); redirect = 1'b0;
    step(3);
    chk("pc12", 32'(bus0.pc_o), 32'h000C);
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt valid", 32'(bus0.valid_o), 0);
    chk("halt busy", 32'(bus0.busy_o), 0);
    step(3);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("resume pc", 32'(bus0.pc_o), 32'h000D);
    step();
    stall = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(bus0.valid_o), 0);
    chk("async rst busy", 32'(bus0.busy_o), 0);
    chk("async rst addr0", 32'(bus0.imem_addr), 32'h0000);
    chk("async rst addr1", 32'(bus1.imem_addr), 32'hFFFE);
    stall = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("no output w/o start", 32'(bus0.valid_o), 0);

    exp_acc = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                16'h0006, 16'h0007, 16'h0100, 16'h000A, 16'h000B, 16'h000D};
    chk("accepted count", 32'(got_acc.size()), 32'(exp_acc.size()));
    for (int k = 0; k < exp_acc.size(); k++)
      chk($sformatf("accepted[%0d]", k),
          (k < got_acc.size()) ? 32'(got_acc[k]) : 32'hFFFF_FFFF, 32'(exp_acc[k]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
